// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and GF(2^8) helpers used by the
// encryption round controller and its combinational round datapath.
package aes_pkg;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse computed as b^254 (so 0 maps to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES encryption round; the final round skips MixColumns.
module aes_round_dp
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t rk,
    input  logic   last_round,
    output block_t next_state
);
    block_t sb, sr, mc;

    sub_bytes   u_sub_bytes   (.din(state), .dout(sb));
    shift_rows  u_shift_rows  (.din(sb),    .dout(sr));
    mix_columns u_mix_columns (.din(sr),    .dout(mc));

    assign next_state = (last_round ? sr : mc) ^ rk;
endmodule

// File: rtl/mix_columns.sv
// AES MixColumns: each 32-bit column multiplied by the fixed {02,03,01,01} circulant.
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127 - 32*c -: 8];
        assign a1 = din[119 - 32*c -: 8];
        assign a2 = din[111 - 32*c -: 8];
        assign a3 = din[103 - 32*c -: 8];
        assign dout[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows on a column-major state with byte 0 at bits [127:120].
module shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r of output column c comes from input column (c + r) mod 4.
            assign dout[127 - 8*(4*c + r) -: 8] = din[127 - 8*(4*((c + r) % 4) + r) -: 8];
        end
    end
endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes: independent S-box substitution of all 16 state bytes.
module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar g = 0; g < 16; g++) begin : g_byte
        assign dout[8*g +: 8] = sbox(din[8*g +: 8]);
    end
endmodule

// File: rtl/aes_enc_round_ctrl.sv
// AES encryption round controller: walks one 128-bit state through INIT, NR-1 full
// rounds and FINAL, fetching one round key per step and stalling while rk_valid is low.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    ctrl_state_e fsm, fsm_nxt;
    logic [3:0]  rnd, rnd_nxt;
    block_t      st, st_nxt, dp_out;

    aes_round_dp u_dp (
        .state      (st),
        .rk         (rk_data),
        .last_round (fsm == FINAL),
        .next_state (dp_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            rnd <= '0;
            st  <= '0;
        end else begin
            fsm <= fsm_nxt;
            rnd <= rnd_nxt;
            st  <= st_nxt;
        end
    end

    // Every key-consuming step advances only on rk_valid; otherwise all state holds.
    always_comb begin
        fsm_nxt   = fsm;
        rnd_nxt   = rnd;
        st_nxt    = st;
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = 4'd0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (fsm)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    st_nxt  = in_data;
                    rnd_nxt = 4'd0;
                    fsm_nxt = INIT;
                end
            end
            INIT: begin
                rk_req = 1'b1;
                rk_idx = rnd;
                if (rk_valid) begin
                    st_nxt  = st ^ rk_data;
                    rnd_nxt = 4'd1;
                    fsm_nxt = ROUND;
                end
            end
            ROUND: begin
                rk_req = 1'b1;
                rk_idx = rnd;
                if (rk_valid) begin
                    st_nxt  = dp_out;
                    rnd_nxt = rnd + 4'd1;
                    fsm_nxt = (rnd == 4'(NR - 1)) ? FINAL : ROUND;
                end
            end
            FINAL: begin
                rk_req = 1'b1;
                rk_idx = rnd;
                if (rk_valid) begin
                    st_nxt  = dp_out;
                    fsm_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = st;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end
endmodule
